// File: rtl/xnor_bist_pkg.sv
// xnor_bist_pkg: FSM encoding and expected-output table for the XNOR cell self-test.
package xnor_bist_pkg;
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;
    localparam int NUM_VECTORS = 4;
    localparam logic [NUM_VECTORS-1:0] XNOR_EXP = 4'b1001;
endpackage

// File: rtl/xnor_bist_timer.sv
// xnor_bist_timer: loadable settle down-counter with a zero flag.
module xnor_bist_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - W'(1);
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/xnor_bist_ctrl.sv
// xnor_bist_ctrl: sequences all four vectors through the XNOR cell and scores its output.
// Defining XNOR_BIST_LOOP_EN lets a held start wrap the run for repeated passes.
module xnor_bist_ctrl
    import xnor_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);
`ifdef XNOR_BIST_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);

    state_t     state, state_n;
    logic [1:0] idx;
    logic       zero, launch, last, miss;

    assign launch = (state == IDLE || state == DONE) && start;
    assign last   = idx == 2'(NUM_VECTORS - 1);
    assign miss   = gate_y != XNOR_EXP[idx];

    xnor_bist_timer #(.W(CW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == APPLY),
        .en      (state == SETTLE),
        .load_val(SETTLE_LOAD),
        .zero    (zero)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = start ? APPLY : state;
            APPLY:      state_n = SETTLE_CYCLES > 0 ? SETTLE : SAMPLE;
            SETTLE:     state_n = zero ? SAMPLE : SETTLE;
            SAMPLE:     state_n = !last ? APPLY : (LOOP_EN && start) ? APPLY : DONE;
            default:    state_n = IDLE;
        endcase
    end

    // idx wraps 3 -> 0 on its own, which is exactly the looped restart
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            state <= state_n;
            if (launch) begin
                idx       <= '0;
                err_count <= '0;
                fail_vec  <= '0;
            end else if (state == SAMPLE) begin
                idx <= idx + 2'd1;
                if (miss) begin
                    err_count     <= &err_count ? err_count : err_count + ERR_W'(1);
                    fail_vec[idx] <= 1'b1;
                end
            end
        end
    end

    assign busy   = state == APPLY || state == SETTLE || state == SAMPLE;
    assign done   = state == DONE;
    assign pass   = done && err_count == '0;
    assign gate_a = busy & idx[1];
    assign gate_b = busy & idx[0];
endmodule

// File: tb/tb_xnor_bist_ctrl.sv
// tb_xnor_bist_ctrl: scoreboard bench for xnor_bist_ctrl with a switchable cell model.
module tb_xnor_bist_ctrl;
    typedef struct packed {
        logic [3:0] err;
        logic [3:0] fv;
        logic       pass;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n, start, gate_a, gate_b, gate_y, busy, done, pass;
    logic [3:0] err_count, fail_vec;
    int         mode = 0;
    int         n_vec = 0, n_err = 0, lp_cyc;
    logic [1:0] pin_q[$];
    res_t       res_q[$];

    always #5 clk = ~clk;

    function automatic logic cell_y(input int m, input logic a, input logic b);
        return m == 0 ? ~(a ^ b) : m == 1 ? (a ^ b) : 1'b1;
    endfunction

    assign gate_y = cell_y(mode, gate_a, gate_b);

    xnor_bist_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .gate_a   (gate_a),
        .gate_b   (gate_b),
        .gate_y   (gate_y),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .fail_vec (fail_vec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_a"}, gate_a, 0);
        check({tag, "_b"}, gate_b, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_fv"}, fail_vec, 0);
    endtask

    task automatic run(input int m, input int abort_cyc, input int mid_cyc);
        res_t       r;
        int         cyc;
        logic [1:0] pv;
        logic       a, b;
        mode = m;
        r = '0;
        for (int v = 0; v < 4; v++) begin
            a = v[1];
            b = v[0];
            if (cell_y(m, a, b) !== (a == b)) begin
                r.err = r.err + 4'd1;
                r.fv[v] = 1'b1;
            end
            repeat (4) pin_q.push_back(2'(v));
        end
        r.pass = r.err == 0;
        res_q.push_back(r);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk_zero("abort");
                pin_q.delete();
                void'(res_q.pop_front());
                return;
            end
            pv = pin_q.size() != 0 ? pin_q.pop_front() : 2'bxx;
            check("pins", {gate_a, gate_b}, pv);
            check("done_low", done, 0);
            start = cyc == mid_cyc;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        pin_q.delete();
        check("busy_len", cyc, 16);
        r = res_q.pop_front();
        check("done", done, 1);
        check("pass", pass, r.pass);
        check("err", err_count, r.err);
        check("fv", fail_vec, r.fv);
        check("pins_idle", {gate_a, gate_b}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_zero("rst");
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk_zero("idle");
        run(0, -1, -1);
        run(1, -1, -1);
        run(2, -1, -1);
        run(0, 9, -1);
        run(0, -1, -1);
        run(0, -1, 6);
`ifdef XNOR_BIST_LOOP_EN
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        lp_cyc = 0;
        while (busy && lp_cyc < 200) begin
            if (lp_cyc == 70) start = 1'b0;
            lp_cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("loop_len", lp_cyc, 80);
        check("loop_err", err_count, 15);
        check("loop_fv", fail_vec, 4'b1111);
        check("loop_done", done, 1);
        check("loop_pass", pass, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/xnor_bist_ctrl.md
# xnor_bist_ctrl

Self-test sequencer for the 2-input gate-level XNOR cell. On `start`, it drives the cell's inputs through all four (A, B) vectors, waits a settle interval, samples the cell output and compares it with the expected XNOR result. It accumulates an error count and a per-vector fail map, then reports `done` and `pass`. It sits beside the XNOR cell as its only input driver during test.

## Interface
- `SETTLE_CYCLES`, default 2: idle cycles between applying a vector and sampling `gate_y`; 0 is legal.
- `ERR_W`, default 4: width of `err_count`.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a test run; sampled in IDLE or DONE only.
- `gate_a`  out  1  XNOR cell input A.
- `gate_b`  out  1  XNOR cell input B.
- `gate_y`  in  1  XNOR cell output Y.
- `busy`  out  1  run in progress (APPLY, SETTLE or SAMPLE).
- `done`  out  1  run complete; level, held until the next start or reset.
- `pass`  out  1  `done` and `err_count` equal to 0.
- `err_count`  out  ERR_W  mismatches counted this run; saturates at 2^ERR_W−1.
- `fail_vec`  out  4  bit i set when vector i mismatched.

## Operation
- Vector index `idx` is 2 bits, 0..3.
- Applied inputs: `gate_a` = idx[1], `gate_b` = idx[0].
- Expected output: bit idx of the constant 4'b1001, i.e. vectors 0..3 expect 1, 0, 0, 1.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE or DONE with `start`=1 → APPLY. On the same edge: idx=0, `err_count`=0, `fail_vec`=0, `done`=0.
- APPLY (1 cycle): drive the vector → SETTLE if SETTLE_CYCLES>0, else → SAMPLE.
- SETTLE: down-counter loaded with SETTLE_CYCLES−1. → SAMPLE when the counter reaches 0.
- SAMPLE (1 cycle): compare `gate_y` against the expected bit.
  - On mismatch: `err_count` increments, saturating; `fail_vec[idx]` is set.
  - If idx=3 → DONE; else idx increments → APPLY.
- `gate_a`/`gate_b` stay stable from APPLY through SAMPLE of the same vector.
- `gate_a`/`gate_b` are 0 in IDLE and DONE.
- `start` is ignored while `busy`=1.
- `pass` is combinational from `done` and `err_count`.

## Timing
- Reset: on any edge with `rst_n`=0, the next state is IDLE. All outputs read 0: `gate_a`, `gate_b`, `busy`, `done`, `pass`, `err_count`, `fail_vec`.
- Reset mid-run aborts immediately. No partial results are retained.
- Start latency: `start` is high at edge N; `busy`=1 and vector 0 is on the pins after edge N.
- Cycles per vector: 2 + SETTLE_CYCLES.
- Full run: 4 × (2 + SETTLE_CYCLES) cycles. This is 16 cycles with the default SETTLE_CYCLES.
- `done` rises on the edge that leaves SAMPLE of vector 3. `busy` falls on that same edge.
- `gate_y` is sampled at the edge that ends SAMPLE. The cell is combinational, so the settle interval only absorbs bench-modelled delay.
- Simultaneous `start` and `rst_n`=0: reset wins.
- Saturation: once `err_count` holds all ones, further mismatches leave it unchanged. `fail_vec` bits still set.

## Configuration
- Macro: `XNOR_BIST_LOOP_EN`.
- Defined: in SAMPLE with idx=3, if `start`=1 the FSM wraps to APPLY with idx=0 instead of entering DONE.
  - `err_count` and `fail_vec` accumulate across passes.
  - DONE is entered at the first final sample with `start`=0.
- Undefined: single pass only. `start` is not examined during a run.

## Structure
- Package `xnor_bist_pkg`, holding:
  - the FSM state encoding;
  - `NUM_VECTORS`=4;
  - `XNOR_EXP`=4'b1001, the expected-output table indexed by idx.
- Sub-module `xnor_bist_timer`: a loadable settle down-counter with a `zero` flag, instantiated once.
- Everything else is flat in `xnor_bist_ctrl`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `start`=1 → every output reads 0, and `busy` stays 0.
- Good cell with defaults: 1-cycle `start` pulse →
  - `busy`=1 for exactly 16 cycles;
  - (A, B) sequence 00, 01, 10, 11, each held for 4 cycles;
  - then `done`=1, `pass`=1, `err_count`=0, `fail_vec`=4'b0000.
- XOR substituted for the cell → `err_count`=4, `fail_vec`=4'b1111, `pass`=0.
- `gate_y` stuck at 1 → `fail_vec`=4'b0110, `err_count`=2, `pass`=0.
- Disturbances on a good cell:
  - `rst_n`=0 during SETTLE of vector 2 → all outputs 0 after that edge; a new `start` then completes with `pass`=1.
  - `start` pulsed mid-run → ignored, and the run still ends at cycle 16.
  - `start` in DONE → counters clear and a fresh run begins.
- With `XNOR_BIST_LOOP_EN`, XOR cell, `start` held for 5 passes, then dropped → `err_count` saturates at 15, `fail_vec`=4'b1111, and `done` asserts only after the pass in which `start` fell.
